// File: rtl/pipe_pkg.sv
//==============================================================================
// pipe_pkg : shared types for the generic pipeline stage register
// Rev 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [1:0] spare;
        logic [3:0] alu_ctrl;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] func3;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = 8;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
//==============================================================================
// pipe_slot : one payload entry (data + control) with load and ctrl-clear
// Rev 1.0
//==============================================================================
`default_nettype none

module pipe_slot #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] data_d, data_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    // Clearing control wins over loading so a bubble can never carry live ctrl.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (load) begin
            data_d = d_data;
            ctrl_d = d_ctrl;
        end
        if (clr_ctrl) begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign q_data = data_q;
    assign q_ctrl = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//==============================================================================
// pipe_stage_reg : generic valid/ready pipeline register with skid and flush
// Rev 1.0
//==============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int CTRL_W      = 16,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e            state_d, state_q;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;
    logic                   in_xfer, out_xfer;
    logic                   main_load, main_clr, main_from_skid;
    logic                   skid_load, skid_clr;
    logic [DATA_W-1:0]      main_src_data, skid_data;
    logic [CTRL_W-1:0]      main_src_ctrl, skid_ctrl;

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = MAIN;
                    end
                end
                MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end else if (in_xfer) begin
                        // Only reachable with a skid slot; without one in_ready is low here.
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = MAIN;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_src_data = main_from_skid ? skid_data : in_data;
    assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .d_data   (main_src_data),
        .d_ctrl   (main_src_ctrl),
        .q_data   (out_data),
        .q_ctrl   (out_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_d, in_ready_q;

            assign in_ready_d = (state_d != FULL);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk      (clk),
                .reset_n  (reset_n),
                .load     (skid_load),
                .clr_ctrl (skid_clr),
                .d_data   (in_data),
                .d_ctrl   (in_ctrl),
                .q_data   (skid_data),
                .q_ctrl   (skid_ctrl)
            );
        end else begin : g_no_skid
            assign in_ready  = !out_valid || out_ready;
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//==============================================================================
// tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg (SKID=1)
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DATA_W      = 16;
    localparam int CTRL_W      = 16;
    localparam int STALL_CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [CTRL_W-1:0]      in_ctrl;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [CTRL_W-1:0]      out_ctrl;
    logic [STALL_CNT_W-1:0] stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .SKID        (1),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        in_ctrl   = 16'h0013;
        out_ready = 1'b1;

        // Reset held for two cycles with a live input present
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Fill: one-cycle latency
        tick();
        chk("fill_valid", 32'(out_valid), 32'd1);
        chk("fill_data",  32'(out_data),  32'h00A5);
        chk("fill_ctrl",  32'(out_ctrl),  32'h0013);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            in_ctrl = 16'(i + 16'h0100);
            tick();
            chk("stream_data",  32'(out_data),  32'(i));
            chk("stream_ctrl",  32'(out_ctrl),  32'(i + 16'h0100));
            chk("stream_ready", 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ctrl",  32'(out_ctrl),  32'd0);
        chk("drain_stall", 32'(stall_cnt), 32'd0);

        // Backpressure: three inputs offered, two accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        in_ctrl   = 16'h0001;
        tick();
        chk("bp1_ready", 32'(in_ready), 32'd1);
        chk("bp1_data",  32'(out_data), 32'd1);
        in_data = 16'd2;
        in_ctrl = 16'h0002;
        tick();
        chk("bp2_ready", 32'(in_ready),  32'd0);
        chk("bp2_data",  32'(out_data),  32'd1);
        chk("bp2_stall", 32'(stall_cnt), 32'd1);
        in_data = 16'd3;
        in_ctrl = 16'h0003;
        tick();
        tick();
        chk("bp3_ready", 32'(in_ready),  32'd0);
        chk("bp3_stall", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_data",  32'(out_data), 32'd2);
        chk("bp_rel_ctrl",  32'(out_ctrl), 32'h0002);
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_in3_data", 32'(out_data), 32'd3);
        in_valid = 1'b0;
        tick();
        chk("bp_end_valid", 32'(out_valid), 32'd0);
        chk("bp_end_stall", 32'(stall_cnt), 32'd3);

        // Flush while FULL with an input presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0011;
        in_ctrl   = 16'h0011;
        tick();
        in_data = 16'h0022;
        in_ctrl = 16'h0022;
        tick();
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_data",  32'(out_data), 32'h0011);
        flush   = 1'b1;
        in_data = 16'h0033;
        in_ctrl = 16'h0033;
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ctrl",  32'(out_ctrl),  32'd0);
        chk("flush_ready", 32'(in_ready),  32'd1);
        chk("flush_stall", 32'(stall_cnt), 32'd5);
        // Input offered during flush with in_ready high is still dropped
        in_data = 16'h0055;
        in_ctrl = 16'h0055;
        tick();
        chk("flush_drop_valid", 32'(out_valid), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        in_data   = 16'h0044;
        in_ctrl   = 16'h0044;
        tick();
        chk("post_flush_data", 32'(out_data), 32'h0044);
        chk("post_flush_ctrl", 32'(out_ctrl), 32'h0044);
        in_valid = 1'b0;
        tick();
        chk("post_flush_empty", 32'(out_valid), 32'd0);

        // Async reset mid-stream while FULL, between clock edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0066;
        in_ctrl   = 16'h0066;
        tick();
        in_data = 16'h0077;
        in_ctrl = 16'h0077;
        tick();
        chk("pre_arst_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrl",  32'(out_ctrl),  32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        reset_n = 1'b1;

        // Stall counter saturation
        in_valid = 1'b1;
        in_data  = 16'h0009;
        in_ctrl  = 16'h0009;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_mid",  32'(stall_cnt), 32'd14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_full", 32'(stall_cnt), 32'd15);
        chk("sat_hold", 32'(out_data),  32'h0009);
        out_ready = 1'b1;
        tick();
        chk("sat_drain", 32'(out_valid), 32'd0);
        chk("sat_keep",  32'(stall_cnt), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
